// File: rtl/mxbiu_if.sv
// mxbiu_if: groups the LSU-side and memory-side signals of the bus interface unit.
// The slave modport is the BIU view; the master modport is the LSU/memory environment view.
interface mxbiu_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // LSU load channel
  logic [ADDR_WIDTH-1:0] biu_rd_addr;
  logic                  biu_load;
  logic                  biu_load_ready;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic                  biu_load_valid;
  // LSU store channel
  logic [ADDR_WIDTH-1:0] biu_wr_addr;
  logic [DATA_WIDTH-1:0] biu_wdata;
  logic                  biu_store;
  logic                  biu_store_ready;
  logic                  biu_store_valid;
  // Memory channel
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  // Status
  logic                  bus_err;

  modport slave (
    input  biu_rd_addr, biu_load, biu_wr_addr, biu_wdata, biu_store,
    input  mem_rdata, mem_ack,
    output biu_load_ready, biu_rdata, biu_load_valid,
    output biu_store_ready, biu_store_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output biu_rd_addr, biu_load, biu_wr_addr, biu_wdata, biu_store,
    output mem_rdata, mem_ack,
    input  biu_load_ready, biu_rdata, biu_load_valid,
    input  biu_store_ready, biu_store_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mxbiu.sv
// mxbiu: single-outstanding bus interface unit between an LSU and a simple
// req/ack memory. Stores win over loads when both are requested in IDLE.
// Optional memory-ack timeout is enabled by defining MXBIU_TIMEOUT_EN; without
// it RD/WR wait indefinitely and bus_err is tied low.
module mxbiu #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic        clk,
  input logic        rst_n,
  mxbiu_if.slave     bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mxbiu: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  is_load_q, is_load_d;

`ifdef MXBIU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_load_q <= 1'b0;
`ifdef MXBIU_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_load_q <= is_load_d;
`ifdef MXBIU_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, wait for ack (or timeout), one-cycle RESP.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_load_d = is_load_q;
`ifdef MXBIU_TIMEOUT_EN
    cnt_d     = '0;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.biu_store) begin
          state_d   = WR;
          req_d     = 1'b1;
          we_d      = 1'b1;
          addr_d    = bus.biu_wr_addr;
          wdata_d   = bus.biu_wdata;
          is_load_d = 1'b0;
        end else if (bus.biu_load) begin
          state_d   = RD;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = bus.biu_rd_addr;
          is_load_d = 1'b1;
        end
      end
      RD, WR: begin
        // A real ack beats a timeout landing in the same cycle.
        if (bus.mem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (state_q == RD) rdata_d = bus.mem_rdata;
`ifdef MXBIU_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (state_q == RD) rdata_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.biu_load_ready  = (state_q == IDLE);
  assign bus.biu_store_ready = (state_q == IDLE);
  assign bus.biu_load_valid  = (state_q == RESP) &&  is_load_q;
  assign bus.biu_store_valid = (state_q == RESP) && !is_load_q;
  assign bus.biu_rdata       = rdata_q;
  assign bus.mem_req         = req_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;
`ifdef MXBIU_TIMEOUT_EN
  assign bus.bus_err         = err_q;
`else
  assign bus.bus_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mxbiu.sv
// tb_mxbiu: directed bench for mxbiu. Inputs change on the falling edge,
// outputs are checked on the falling edge, away from the active rising edge.
module tb_mxbiu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mxbiu_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  mxbiu #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    int reqs;
    bus.biu_rd_addr = '0;
    bus.biu_load    = 1'b0;
    bus.biu_wr_addr = '0;
    bus.biu_wdata   = '0;
    bus.biu_store   = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_ack     = 1'b0;

    // Reset state
    nclk(); nclk();
    chk("rst_req",        bus.mem_req, 0);
    chk("rst_we",         bus.mem_we, 0);
    chk("rst_addr",       bus.mem_addr, 0);
    chk("rst_wdata",      bus.mem_wdata, 0);
    chk("rst_rdata",      bus.biu_rdata, 0);
    chk("rst_lvalid",     bus.biu_load_valid, 0);
    chk("rst_svalid",     bus.biu_store_valid, 0);
    chk("rst_err",        bus.bus_err, 0);
    chk("rst_lready",     bus.biu_load_ready, 1);
    chk("rst_sready",     bus.biu_store_ready, 1);
    rst_n = 1'b1;

    // Load 0x3C, ack after two wait cycles with 0xA5
    nclk();
    bus.biu_load = 1'b1; bus.biu_rd_addr = 8'h3C;
    nclk();
    bus.biu_load = 1'b0;
    chk("ld_req1",   bus.mem_req, 1);
    chk("ld_we",     bus.mem_we, 0);
    chk("ld_addr",   bus.mem_addr, 8'h3C);
    chk("ld_ready",  bus.biu_load_ready, 0);
    nclk();
    chk("ld_req2",   bus.mem_req, 1);
    nclk();
    chk("ld_req3",   bus.mem_req, 1);
    chk("ld_addr3",  bus.mem_addr, 8'h3C);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
    nclk();
    bus.mem_ack = 1'b0;
    chk("ld_req_off", bus.mem_req, 0);
    chk("ld_valid",   bus.biu_load_valid, 1);
    chk("ld_svalid",  bus.biu_store_valid, 0);
    chk("ld_rdata",   bus.biu_rdata, 8'hA5);
    chk("ld_rready",  bus.biu_load_ready, 0);
    nclk();
    chk("ld_valid_end", bus.biu_load_valid, 0);
    chk("ld_idle_rdy",  bus.biu_load_ready, 1);
    chk("ld_hold",      bus.biu_rdata, 8'hA5);

    // Store 0x55 to 0x10, ack next cycle
    bus.biu_store = 1'b1; bus.biu_wr_addr = 8'h10; bus.biu_wdata = 8'h55;
    nclk();
    bus.biu_store = 1'b0;
    chk("st_req",    bus.mem_req, 1);
    chk("st_we",     bus.mem_we, 1);
    chk("st_addr",   bus.mem_addr, 8'h10);
    chk("st_wdata",  bus.mem_wdata, 8'h55);
    chk("st_sready", bus.biu_store_ready, 0);
    bus.mem_ack = 1'b1;
    nclk();
    bus.mem_ack = 1'b0;
    chk("st_valid",  bus.biu_store_valid, 1);
    chk("st_lvalid", bus.biu_load_valid, 0);
    chk("st_req_off", bus.mem_req, 0);
    chk("st_rdhold", bus.biu_rdata, 8'hA5);
    nclk();
    chk("st_valid_end", bus.biu_store_valid, 0);

    // Simultaneous load and store: store first, load after RESP
    bus.biu_load = 1'b1;  bus.biu_rd_addr = 8'h20;
    bus.biu_store = 1'b1; bus.biu_wr_addr = 8'h30; bus.biu_wdata = 8'h77;
    nclk();
    bus.biu_store = 1'b0;
    chk("both_we",   bus.mem_we, 1);
    chk("both_addr", bus.mem_addr, 8'h30);
    chk("both_wd",   bus.mem_wdata, 8'h77);
    bus.mem_ack = 1'b1;
    nclk();
    bus.mem_ack = 1'b0;
    chk("both_svalid", bus.biu_store_valid, 1);
    chk("both_lready", bus.biu_load_ready, 0);
    nclk();
    chk("both_idle",   bus.biu_load_ready, 1);
    chk("both_noreq",  bus.mem_req, 0);
    nclk();
    bus.biu_load = 1'b0;
    chk("both_ldreq",  bus.mem_req, 1);
    chk("both_ldwe",   bus.mem_we, 0);
    chk("both_ldaddr", bus.mem_addr, 8'h20);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    nclk();
    bus.mem_ack = 1'b0;
    chk("both_lvalid", bus.biu_load_valid, 1);
    chk("both_rdata",  bus.biu_rdata, 8'h5A);
    nclk();
    chk("both_lv_end", bus.biu_load_valid, 0);

    // Ack while IDLE is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    nclk();
    bus.mem_ack = 1'b0;
    chk("ign_req",    bus.mem_req, 0);
    chk("ign_lvalid", bus.biu_load_valid, 0);
    chk("ign_rdata",  bus.biu_rdata, 8'h5A);
    chk("ign_ready",  bus.biu_load_ready, 1);

    // Reset in the middle of a load
    bus.biu_load = 1'b1; bus.biu_rd_addr = 8'h44;
    nclk();
    bus.biu_load = 1'b0;
    chk("mid_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_off", bus.mem_req, 0);
    chk("mid_addr",    bus.mem_addr, 0);
    chk("mid_rdata",   bus.biu_rdata, 0);
    chk("mid_ready",   bus.biu_load_ready, 1);
    nclk();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99;
    nclk();
    bus.mem_ack = 1'b0;
    chk("post_lvalid", bus.biu_load_valid, 0);
    chk("post_req",    bus.mem_req, 0);
    chk("post_ready",  bus.biu_load_ready, 1);
    nclk();
    chk("post_lvalid2", bus.biu_load_valid, 0);
    chk("post_rdata",   bus.biu_rdata, 0);

`ifdef MXBIU_TIMEOUT_EN
    // Unacked load times out after 15 request cycles
    bus.biu_load = 1'b1; bus.biu_rd_addr = 8'h66;
    nclk();
    bus.biu_load = 1'b0;
    reqs = 0;
    for (int i = 0; i < 40 && bus.mem_req; i++) begin
      reqs++;
      nclk();
    end
    chk("to_reqcycles", reqs, 15);
    chk("to_err",    bus.bus_err, 1);
    chk("to_lvalid", bus.biu_load_valid, 1);
    chk("to_rdata",  bus.biu_rdata, 8'hFF);
    nclk();
    chk("to_err_end", bus.bus_err, 0);
    // Ack on the limit cycle wins over the timeout
    bus.biu_load = 1'b1; bus.biu_rd_addr = 8'h67;
    nclk();
    bus.biu_load = 1'b0;
    for (int i = 0; i < 14; i++) nclk();
    chk("edge_req", bus.mem_req, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h12;
    nclk();
    bus.mem_ack = 1'b0;
    chk("edge_err",    bus.bus_err, 0);
    chk("edge_lvalid", bus.biu_load_valid, 1);
    chk("edge_rdata",  bus.biu_rdata, 8'h12);
    nclk();
`else
    // Without the timeout, an unacked load waits indefinitely
    bus.biu_load = 1'b1; bus.biu_rd_addr = 8'h66;
    nclk();
    bus.biu_load = 1'b0;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req && !bus.biu_load_valid && !bus.bus_err) reqs++;
      nclk();
    end
    chk("nto_reqcycles", reqs, 20);
    chk("nto_req",    bus.mem_req, 1);
    chk("nto_err",    bus.bus_err, 0);
    chk("nto_ready",  bus.biu_load_ready, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
    nclk();
    bus.mem_ack = 1'b0;
    chk("nto_lvalid", bus.biu_load_valid, 1);
    chk("nto_rdata",  bus.biu_rdata, 8'hC3);
    nclk();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
